dll_multi_list: RTL
===================

Name: dll_multi_list

Overview:
- Parametrised successor to the single doubly linked list engine.
- NUM_LISTS independent doubly linked lists share one node pool of MAX_NODE entries, managed through an internal free bitmap.
- Every operation names a target list, so several traffic classes or queues can share one storage array.
- Sits where the single-list block sat, and adds per-list ownership checking, overwrite, pop-tail and insert-before operations.

Parameters:
- DATA_WIDTH, 8: payload width.
- MAX_NODE, 8: node pool depth (>=2).
- NUM_LISTS, 2: number of independent lists (>=1).
- LID_WIDTH, $clog2(NUM_LISTS)>0 ? $clog2(NUM_LISTS) : 1: list-id width.
- ADDR_WIDTH, $clog2(MAX_NODE)+1: node address width. NULL_ADDR = all ones (15 at defaults), never a real node.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- op_start  in  1  request pulse, sampled only in IDLE
- op  in  3  operation code
- list_id  in  LID_WIDTH  target list
- addr_in  in  ADDR_WIDTH  node address for READ/WRITE/INSERT_BEFORE/DELETE
- data_in  in  DATA_WIDTH  payload
- op_done  out  1  one-cycle completion pulse
- busy  out  1  high in any non-IDLE state
- fault  out  1  valid with op_done; operation rejected, no state change
- data_out  out  DATA_WIDTH  node data
- pre_node_addr  out  ADDR_WIDTH  node's prev pointer
- next_node_addr  out  ADDR_WIDTH  node's next pointer
- result_addr  out  ADDR_WIDTH  node touched or allocated
- length  out  ADDR_WIDTH  node count of the operated list
- head  out  ADDR_WIDTH  head of the operated list
- tail  out  ADDR_WIDTH  tail of the operated list
- empty  out  1  operated list has no nodes
- full  out  1  pool has no free node (live)
- free_cnt  out  ADDR_WIDTH  number of free nodes (live)

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - All nodes freed; every list's head/tail = NULL, length = 0.
  - FSM returns to IDLE.
  - op_done = busy = fault = 0; data_out = 0.
  - pre_node_addr, next_node_addr, result_addr, head, tail = NULL.
  - length = 0, empty = 1, full = 0, free_cnt = MAX_NODE.
- FSM states and transitions:
  - IDLE --op_start--> EXEC: op, list_id, addr_in and data_in are registered.
  - EXEC: legality check plus pointer and bitmap update, all in one cycle.
  - EXEC --> DONE: op_done = 1 for exactly one cycle; result outputs update in the same cycle.
  - DONE --> IDLE.
  - Latency: op_done is high 2 cycles after the op_start sampling edge. Back-to-back throughput is 1 op per 3 cycles.
  - op_start while busy is ignored, with no queueing.
- Operation codes:
  - 0 READ: return data and prev/next of addr_in.
  - 1 WRITE: overwrite data of addr_in; pointers unchanged.
  - 2 PUSH_HEAD: allocate a node and link it as the new head.
  - 3 PUSH_TAIL: allocate a node and link it as the new tail.
  - 4 POP_HEAD: return data of the head node, then free it.
  - 5 POP_TAIL: return data of the tail node, then free it.
  - 6 INSERT_BEFORE: allocate a node and link it ahead of addr_in. If addr_in is the head, the new node becomes the head.
  - 7 DELETE: unlink and free addr_in, patching the neighbour pointers.
- Allocation always takes the lowest-index free node, so results are deterministic.
- A freed node's prev/next are set to NULL.
- Outputs per operation type:
  - Pops and DELETE: data_out/prev/next show the removed node's values before removal.
  - Pushes and INSERT_BEFORE: result_addr = new node; data_out = data_in.
- Fault conditions (no state change; data_out keeps its last value; other result outputs hold):
  - addr_in >= MAX_NODE, addr_in free, or addr_in owned by a different list (ops 0, 1, 6, 7).
  - Pool full on ops 2, 3, 6.
  - Target list empty on ops 4, 5.
  - list_id >= NUM_LISTS on any op.
- Boundary conditions:
  - Removing the last node of a list sets that list's head = tail = NULL and empty = 1.
  - Pushing into an empty list sets head = tail = the new node.
  - full and free_cnt update on the DONE cycle.
  - Lists never share nodes.

Optional Feature:
- Macro: DLL_LIST_CLEAR_EN.
- When defined:
  - Adds input list_clear (1 bit), sampled in IDLE.
  - If op_start and list_clear are both high, op_start wins.
  - On accept, the block enters state CLEAR and frees one node per cycle, walking from head to tail, then goes to DONE.
  - op_done fires length+2 cycles after accept (2 cycles for an empty list).
  - fault is asserted only for an invalid list_id.
- When undefined: the port and CLEAR state do not exist.

Test Plan:
- Reset, then PUSH_TAIL list0 data 0xA1, 0xA2, 0xA3 -> result_addr 0, 1, 2; list0 head = 0, tail = 2, length = 3; free_cnt = 5.
- PUSH_HEAD list1 data 0x55, then READ list1 addr 3 -> op_done 2 cycles after op_start; data_out = 0x55; pre = next = 15; fault = 0.
- READ list1 addr 1 (owned by list0) -> fault = 1; no state change.
- POP_TAIL on empty list1 after its single POP_HEAD -> fault = 1.
- DELETE list0 addr 1 -> node0.next = 2, node2.prev = 0, length = 2. Then INSERT_BEFORE list0 addr 0 data 0x77 -> result_addr = 1 (reused), head = 1.
- Fill pool to 8 nodes -> full = 1; next PUSH fault = 1. Assert rst_n low during EXEC -> all outputs at reset values immediately; free_cnt = 8.

Source files
------------

// File: rtl/dll_multi_list.sv
// rtl/dll_multi_list.sv - NUM_LISTS doubly linked lists sharing one MAX_NODE node pool
// Optional walk-and-free list clear is enabled by defining DLL_LIST_CLEAR_EN.
module dll_multi_list #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_NODE   = 8,
  parameter int NUM_LISTS  = 2,
  parameter int LID_WIDTH  = ($clog2(NUM_LISTS) > 0) ? $clog2(NUM_LISTS) : 1,
  parameter int ADDR_WIDTH = $clog2(MAX_NODE) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_start,
  input  logic [2:0]            op,
  input  logic [LID_WIDTH-1:0]  list_id,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
`ifdef DLL_LIST_CLEAR_EN
  input  logic                  list_clear,
`endif
  output logic                  op_done,
  output logic                  busy,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] pre_node_addr,
  output logic [ADDR_WIDTH-1:0] next_node_addr,
  output logic [ADDR_WIDTH-1:0] result_addr,
  output logic [ADDR_WIDTH-1:0] length,
  output logic [ADDR_WIDTH-1:0] head,
  output logic [ADDR_WIDTH-1:0] tail,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] free_cnt
);

  localparam int NW = $clog2(MAX_NODE);
  localparam logic [ADDR_WIDTH-1:0] NULL_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    OP_READ, OP_WRITE, OP_PUSH_HEAD, OP_PUSH_TAIL,
    OP_POP_HEAD, OP_POP_TAIL, OP_INSERT_BEFORE, OP_DELETE
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_DONE
`ifdef DLL_LIST_CLEAR_EN
    , S_CLEAR
`endif
  } state_e;

  state_e state_q, state_d;

  op_e                   r_op;
  logic [LID_WIDTH-1:0]  r_lid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  node_used  [MAX_NODE];
  logic [LID_WIDTH-1:0]  node_owner [MAX_NODE];
  logic [DATA_WIDTH-1:0] node_data  [MAX_NODE];
  logic [ADDR_WIDTH-1:0] node_prev  [MAX_NODE];
  logic [ADDR_WIDTH-1:0] node_next  [MAX_NODE];

  logic [ADDR_WIDTH-1:0] head_q [NUM_LISTS];
  logic [ADDR_WIDTH-1:0] tail_q [NUM_LISTS];
  logic [ADDR_WIDTH-1:0] len_q  [NUM_LISTS];
  logic                  fault_q;

  logic                  lid_ok, a_in_range, addr_ok;
  logic [LID_WIDTH-1:0]  lid_idx;
  logic [NW-1:0]         a_idx, h_idx, t_idx, alloc_idx;
  logic [ADDR_WIDTH-1:0] cur_head, cur_tail, cur_len;
  logic [ADDR_WIDTH-1:0] a_prev, a_next, h_next, t_prev, alloc_addr;
  logic                  alloc_found;
  logic [ADDR_WIDTH-1:0] free_count;

  assign lid_ok     = (int'(r_lid) < NUM_LISTS);
  assign lid_idx    = lid_ok ? r_lid : '0;
  assign a_in_range = (int'(r_addr) < MAX_NODE);
  assign a_idx      = r_addr[NW-1:0];
  assign addr_ok    = lid_ok && a_in_range && node_used[a_idx] && (node_owner[a_idx] == r_lid);
  assign cur_head   = head_q[lid_idx];
  assign cur_tail   = tail_q[lid_idx];
  assign cur_len    = len_q[lid_idx];
  assign h_idx      = cur_head[NW-1:0];
  assign t_idx      = cur_tail[NW-1:0];
  assign a_prev     = node_prev[a_idx];
  assign a_next     = node_next[a_idx];
  assign h_next     = node_next[h_idx];
  assign t_prev     = node_prev[t_idx];
  assign alloc_addr = ADDR_WIDTH'(alloc_idx);

  // Lowest free index wins because the scan runs downward and keeps the last hit.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    free_count  = '0;
    for (int i = MAX_NODE - 1; i >= 0; i--) begin
      if (!node_used[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = NW'(i);
        free_count  = free_count + ADDR_WIDTH'(1);
      end
    end
  end

  assign full     = !alloc_found;
  assign free_cnt = free_count;
  assign busy     = (state_q != S_IDLE);
  assign op_done  = (state_q == S_DONE);
  assign fault    = op_done && fault_q;
  assign empty    = (length == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (op_start) state_d = S_EXEC;
`ifdef DLL_LIST_CLEAR_EN
        else if (list_clear) state_d = S_CLEAR;
`endif
      end
      S_EXEC: state_d = S_DONE;
`ifdef DLL_LIST_CLEAR_EN
      S_CLEAR: if (!lid_ok || cur_head == NULL_ADDR) state_d = S_DONE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  logic                  ex_fault, alloc_en, free_en, wdata_en, pw_en, nw_en;
  logic [NW-1:0]         free_idx, pw_idx, nw_idx;
  logic [ADDR_WIDTH-1:0] alloc_prev, alloc_next, pw_val, nw_val;
  logic [ADDR_WIDTH-1:0] o_pre, o_next, o_res, n_head, n_tail, n_len;
  logic [DATA_WIDTH-1:0] o_data;

  // Decode of one operation: fault, node writes, neighbour patches, new list state.
  always_comb begin
    ex_fault   = 1'b0;
    alloc_en   = 1'b0;
    alloc_prev = NULL_ADDR;
    alloc_next = NULL_ADDR;
    free_en    = 1'b0;
    free_idx   = '0;
    wdata_en   = 1'b0;
    pw_en      = 1'b0;
    pw_idx     = '0;
    pw_val     = NULL_ADDR;
    nw_en      = 1'b0;
    nw_idx     = '0;
    nw_val     = NULL_ADDR;
    o_data     = data_out;
    o_pre      = pre_node_addr;
    o_next     = next_node_addr;
    o_res      = result_addr;
    n_head     = cur_head;
    n_tail     = cur_tail;
    n_len      = cur_len;
    case (r_op)
      OP_READ, OP_WRITE: begin
        ex_fault = !addr_ok;
        wdata_en = (r_op == OP_WRITE);
        o_data   = (r_op == OP_WRITE) ? r_data : node_data[a_idx];
        o_pre    = a_prev;
        o_next   = a_next;
        o_res    = r_addr;
      end
      OP_PUSH_HEAD: begin
        ex_fault   = !lid_ok || !alloc_found;
        alloc_en   = 1'b1;
        alloc_next = cur_head;
        o_data     = r_data;
        o_pre      = NULL_ADDR;
        o_next     = cur_head;
        o_res      = alloc_addr;
        n_head     = alloc_addr;
        n_len      = cur_len + ADDR_WIDTH'(1);
        if (cur_head == NULL_ADDR) n_tail = alloc_addr;
        else begin pw_en = 1'b1; pw_idx = h_idx; pw_val = alloc_addr; end
      end
      OP_PUSH_TAIL: begin
        ex_fault   = !lid_ok || !alloc_found;
        alloc_en   = 1'b1;
        alloc_prev = cur_tail;
        o_data     = r_data;
        o_pre      = cur_tail;
        o_next     = NULL_ADDR;
        o_res      = alloc_addr;
        n_tail     = alloc_addr;
        n_len      = cur_len + ADDR_WIDTH'(1);
        if (cur_tail == NULL_ADDR) n_head = alloc_addr;
        else begin nw_en = 1'b1; nw_idx = t_idx; nw_val = alloc_addr; end
      end
      OP_POP_HEAD: begin
        ex_fault = !lid_ok || (cur_len == '0);
        free_en  = 1'b1;
        free_idx = h_idx;
        o_data   = node_data[h_idx];
        o_pre    = NULL_ADDR;
        o_next   = h_next;
        o_res    = cur_head;
        n_head   = h_next;
        n_len    = cur_len - ADDR_WIDTH'(1);
        if (h_next == NULL_ADDR) n_tail = NULL_ADDR;
        else begin pw_en = 1'b1; pw_idx = h_next[NW-1:0]; end
      end
      OP_POP_TAIL: begin
        ex_fault = !lid_ok || (cur_len == '0);
        free_en  = 1'b1;
        free_idx = t_idx;
        o_data   = node_data[t_idx];
        o_pre    = t_prev;
        o_next   = NULL_ADDR;
        o_res    = cur_tail;
        n_tail   = t_prev;
        n_len    = cur_len - ADDR_WIDTH'(1);
        if (t_prev == NULL_ADDR) n_head = NULL_ADDR;
        else begin nw_en = 1'b1; nw_idx = t_prev[NW-1:0]; end
      end
      OP_INSERT_BEFORE: begin
        ex_fault   = !addr_ok || !alloc_found;
        alloc_en   = 1'b1;
        alloc_prev = a_prev;
        alloc_next = r_addr;
        pw_en      = 1'b1;
        pw_idx     = a_idx;
        pw_val     = alloc_addr;
        o_data     = r_data;
        o_pre      = a_prev;
        o_next     = r_addr;
        o_res      = alloc_addr;
        n_len      = cur_len + ADDR_WIDTH'(1);
        if (a_prev == NULL_ADDR) n_head = alloc_addr;
        else begin nw_en = 1'b1; nw_idx = a_prev[NW-1:0]; nw_val = alloc_addr; end
      end
      OP_DELETE: begin
        ex_fault = !addr_ok;
        free_en  = 1'b1;
        free_idx = a_idx;
        o_data   = node_data[a_idx];
        o_pre    = a_prev;
        o_next   = a_next;
        o_res    = r_addr;
        n_len    = cur_len - ADDR_WIDTH'(1);
        if (a_prev == NULL_ADDR) n_head = a_next;
        else begin nw_en = 1'b1; nw_idx = a_prev[NW-1:0]; nw_val = a_next; end
        if (a_next == NULL_ADDR) n_tail = a_prev;
        else begin pw_en = 1'b1; pw_idx = a_next[NW-1:0]; pw_val = a_prev; end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= OP_READ;
      r_lid  <= '0;
      r_addr <= '0;
      r_data <= '0;
      for (int i = 0; i < MAX_NODE; i++) begin
        node_used[i]  <= 1'b0;
        node_owner[i] <= '0;
        node_data[i]  <= '0;
        node_prev[i]  <= NULL_ADDR;
        node_next[i]  <= NULL_ADDR;
      end
      for (int l = 0; l < NUM_LISTS; l++) begin
        head_q[l] <= NULL_ADDR;
        tail_q[l] <= NULL_ADDR;
        len_q[l]  <= '0;
      end
      fault_q        <= 1'b0;
      data_out       <= '0;
      pre_node_addr  <= NULL_ADDR;
      next_node_addr <= NULL_ADDR;
      result_addr    <= NULL_ADDR;
      length         <= '0;
      head           <= NULL_ADDR;
      tail           <= NULL_ADDR;
    end else begin
      if (state_q == S_IDLE) begin
        r_op   <= op_e'(op);
        r_lid  <= list_id;
        r_addr <= addr_in;
        r_data <= data_in;
      end
      if (state_q == S_EXEC) begin
        fault_q <= ex_fault;
        if (!ex_fault) begin
          if (alloc_en) begin
            node_used[alloc_idx]  <= 1'b1;
            node_owner[alloc_idx] <= r_lid;
            node_data[alloc_idx]  <= r_data;
            node_prev[alloc_idx]  <= alloc_prev;
            node_next[alloc_idx]  <= alloc_next;
          end
          if (free_en) begin
            node_used[free_idx] <= 1'b0;
            node_prev[free_idx] <= NULL_ADDR;
            node_next[free_idx] <= NULL_ADDR;
          end
          if (wdata_en) node_data[a_idx] <= r_data;
          if (pw_en)    node_prev[pw_idx] <= pw_val;
          if (nw_en)    node_next[nw_idx] <= nw_val;
          head_q[lid_idx] <= n_head;
          tail_q[lid_idx] <= n_tail;
          len_q[lid_idx]  <= n_len;
          data_out        <= o_data;
          pre_node_addr   <= o_pre;
          next_node_addr  <= o_next;
          result_addr     <= o_res;
          head            <= n_head;
          tail            <= n_tail;
          length          <= n_len;
        end
      end
`ifdef DLL_LIST_CLEAR_EN
      if (state_q == S_CLEAR) begin
        if (lid_ok && cur_head != NULL_ADDR) begin
          node_used[h_idx] <= 1'b0;
          node_prev[h_idx] <= NULL_ADDR;
          node_next[h_idx] <= NULL_ADDR;
          head_q[lid_idx]  <= h_next;
          len_q[lid_idx]   <= cur_len - ADDR_WIDTH'(1);
          if (h_next == NULL_ADDR) tail_q[lid_idx] <= NULL_ADDR;
        end else begin
          fault_q <= !lid_ok;
          if (lid_ok) begin
            head   <= NULL_ADDR;
            tail   <= NULL_ADDR;
            length <= '0;
          end
        end
      end
`endif
    end
  end

endmodule
